// File: rtl/pedal_sensor_cond.sv
// Pedal sensor conditioning for the desired-drive stage.
// Turns the raw crank cadence level into a debounced rising-edge pulse and a
// per-window cadence count with a not-pedaling flag. It also keeps an
// exponential (1/32 weight) average of strobed torque ADC samples.
//
// Ports:
//   clk           system clock, all logic on the rising edge
//   rst_n         synchronous active-low reset
//   cadence_raw   asynchronous crank sensor level
//   torque_in     unsigned 12-bit torque ADC sample
//   torque_vld    one-cycle strobe qualifying torque_in
//   cadence_rise  one-cycle pulse per debounced rising cadence edge
//   cadence       rises counted in the last completed window, saturating at 31
//   not_pedaling  high while the reported cadence is below 2
//   avg_torque    exponentially averaged torque (upper 12 bits of the accumulator)
module pedal_sensor_cond #(
  parameter int unsigned PERIOD_BITS = 24,
  parameter int unsigned DEB_CYC     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cadence_raw,
  input  logic [11:0] torque_in,
  input  logic        torque_vld,
  output logic        cadence_rise,
  output logic [4:0]  cadence,
  output logic        not_pedaling,
  output logic [11:0] avg_torque
);

  localparam int unsigned DEB_W   = 8;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned TQ_W    = 12;
  localparam int unsigned SHIFT   = 5;
  localparam int unsigned ACC_W   = TQ_W + SHIFT;

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MIN  = CNT_W'(2);

  logic                   sync_q1;
  logic                   sync;
  logic                   filt;
  logic                   filt_d;
  logic [DEB_W-1:0]       deb_cnt;
  logic [PERIOD_BITS-1:0] win_cnt;
  logic [CNT_W-1:0]       rise_cnt;
  logic [ACC_W-1:0]       acc;
  logic [ACC_W-1:0]       acc_upd;
  logic                   seeded;
  logic                   win_last;

  // Two-flop synchronizer; nothing may sit between the stages.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync    <= 1'b0;
    end else begin
      sync_q1 <= cadence_raw;
      sync    <= sync_q1;
    end
  end

  // Debounce: filt only follows sync after DEB_CYC consecutive mismatching clocks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filt    <= 1'b0;
      deb_cnt <= '0;
    end else if (sync != filt) begin
      if (deb_cnt == DEB_LAST) begin
        filt    <= sync;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end else begin
      deb_cnt <= '0;
    end
  end

  // Registered rising-edge pulse of the filtered level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filt_d       <= 1'b0;
      cadence_rise <= 1'b0;
    end else begin
      filt_d       <= filt;
      cadence_rise <= filt & ~filt_d;
    end
  end

  assign win_last = &win_cnt;

  // Measurement window: count rises, publish at the terminal cycle.
  // A rise coinciding with the terminal cycle seeds the next window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_cnt      <= '0;
      rise_cnt     <= '0;
      cadence      <= '0;
      not_pedaling <= 1'b1;
    end else begin
      win_cnt <= win_cnt + PERIOD_BITS'(1);
      if (win_last) begin
        cadence      <= rise_cnt;
        not_pedaling <= (rise_cnt < CNT_MIN);
        rise_cnt     <= cadence_rise ? CNT_ONE : '0;
      end else if (cadence_rise && !(&rise_cnt)) begin
        rise_cnt <= rise_cnt + CNT_ONE;
      end
    end
  end

  // Leaky integrator update; bounded at 4095*32 so 17 bits suffice.
  always_comb begin
    acc_upd = acc - (acc >> SHIFT) + ACC_W'(torque_in);
  end

  // Accumulator: first strobe seeds it so the average starts at the sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc    <= '0;
      seeded <= 1'b0;
    end else if (torque_vld) begin
      if (!seeded) begin
        acc    <= {torque_in, SHIFT'(0)};
        seeded <= 1'b1;
      end else begin
        acc <= acc_upd;
      end
    end
  end

  assign avg_torque = acc[ACC_W-1:SHIFT];

endmodule
